lfsr_arbiter: RTL and testbench
===============================

# lfsr_arbiter

Shares one 8-bit pseudo-random generator between up to NUM_REQ requesters. Round-robin arbitration with bounded burst ownership, seed (re)load, and a registered byte-per-grant delivery path. Sits between the design's consumers of random bytes and the LFSR datapath: it owns the stepping, seeding and zero-state guard, so requesters never drive the LFSR directly.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- BURST_LEN, 4, max consecutive grants one owner keeps while others wait (1..15)
- SEED_DEFAULT, 8'h8A, LFSR value after reset and substitute for a zero seed
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low: reset==0 at a rising edge resets the block
- req  input  NUM_REQ  level request per requester; one byte consumed per cycle of matching gnt
- seed_load  input  1  one-cycle strobe: load seed_in into LFSR
- seed_in  input  8  seed value, sampled when seed_load==1
- gnt  output  NUM_REQ  one-hot (or zero) grant; rnd_data valid for gnt owner this cycle
- rnd_data  output  8  byte delivered with current gnt
- data  output  8  live LFSR state (debug/observe)
- busy  output  1  high while FSM in GRANT

## Operation
- LFSR: Fibonacci, right shift, next = {d[0]^d[2]^d[3]^d[4], d[7:1]} (x^8+x^4+x^3+x^2+1, period 255). Steps only on a grant; otherwise holds.
- FSM states: IDLE, GRANT.
  - IDLE: if any req, pick winner by round-robin from pointer; -> GRANT. Else stay.
  - GRANT: if owner still requests and (burst_cnt < BURST_LEN or no other req) -> stay, same owner (burst_cnt restarts at 1 when continuing alone past BURST_LEN). Else if any other req -> new winner, burst_cnt=1. Else -> IDLE.
- On every edge that issues a grant: gnt <= onehot(winner), rnd_data <= current LFSR state, LFSR steps, pointer <= winner+1 mod NUM_REQ.
- Round-robin: search starts at pointer; reset pointer = 0 (requester 0 highest).
- Seed load: seed_load==1 at an edge overrides arbitration: LFSR <= (seed_in==0 ? SEED_DEFAULT : seed_in), gnt <= 0, FSM -> IDLE, burst_cnt <= 0, pointer unchanged, rnd_data held.
- Zero guard: LFSR state 0 is unreachable; any load of 0 is replaced.
- Reset (reset==0): gnt=0, rnd_data=8'h00, data=SEED_DEFAULT, busy=0, FSM=IDLE, burst_cnt=0, pointer=0. Reset beats seed_load and req.

## Timing
- req sampled at edge t -> gnt/rnd_data valid in cycle t+1 (1-cycle latency); no combinational path req->gnt.
- Back-to-back: one byte per cycle while owner holds req; requester wanting exactly k bytes drops req during its k-th gnt cycle.
- req dropped by non-owner before being granted: no effect, no byte consumed.
- Owner drops req while gnt high: that cycle's byte still counts as delivered; gnt falls next cycle unless re-granted.
- seed_load and grant never in same cycle; first grant after a load delivers the loaded seed.
- data reflects LFSR after the edge, i.e. one step ahead of rnd_data during a grant.

## Structure
- Package lfsr_pkg: LFSR_W=8, SEED_DEFAULT constant, tap function next_state, FSM state enum (IDLE, GRANT).
- Sub-module lfsr_core: ports clk, reset, step, load, load_val, state; holds the 8-bit register and zero guard. lfsr_arbiter instantiates one and contains FSM, pointer, burst counter, output registers.

## Test plan
- Reset low 2 cycles, release, req=0 for 5 cycles -> gnt=0, busy=0, rnd_data=8'h00, data=8'h8A constant.
- req=4'b0001 held 3 cycles then dropped in 3rd gnt cycle -> gnt=4'b0001 for 3 cycles, rnd_data 8'h8A, 8'hC5, 8'h62; then gnt=0, data=8'h31.
- req=4'b1111 held, BURST_LEN=4 -> gnt sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; no idle cycles; rnd_data follows LFSR sequence without gaps.
- seed_load=1, seed_in=8'h00 during a burst -> next cycle gnt=0, data=8'h8A; next grant delivers rnd_data=8'h8A. Repeat with seed_in=8'h5A -> first grant delivers 8'h5A.
- reset=0 for one cycle mid-burst with req=4'b0110 -> next cycle all outputs at reset values; after release, requester 1 granted first (pointer=0).
- Single requester held 256 grants -> rnd_data never 8'h00; grant 256 delivers 8'h8A again (period 255).

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants, LFSR tap function and FSM state type for the LFSR arbiter.
// x^8+x^4+x^3+x^2+1 Fibonacci LFSR, right-shifting, period 255.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 8'h8A;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [LFSR_W-1:0] next_state(input logic [LFSR_W-1:0] d);
    return {d[0] ^ d[2] ^ d[3] ^ d[4], d[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 8-bit LFSR register with load/step controls; a zero value can never be stored,
// so the all-zero lock-up state is unreachable.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;
  logic [LFSR_W-1:0] cand;

  always_comb begin
    cand = state_q;
    if (load) begin
      cand = load_val;
    end else if (step) begin
      cand = next_state(state_q);
    end
    // Guarded on every path so a corrupted register also recovers.
    state_d = (cand == '0) ? SEED : cand;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter sharing one LFSR among NUM_REQ requesters, with bounded
// burst ownership, seed reload and one registered byte per grant cycle.
module lfsr_arbiter #(
  parameter int                          NUM_REQ      = 4,
  parameter int                          BURST_LEN    = 4,
  parameter logic [lfsr_pkg::LFSR_W-1:0] SEED_DEFAULT = 8'h8A
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic                          seed_load,
  input  logic [lfsr_pkg::LFSR_W-1:0]   seed_in,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [lfsr_pkg::LFSR_W-1:0]   rnd_data,
  output logic [lfsr_pkg::LFSR_W-1:0]   data,
  output logic                          busy
);

  import lfsr_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  typedef logic [PTR_W-1:0] ptr_t;

  state_e              state_q, state_d;
  ptr_t                ptr_q, ptr_d;
  ptr_t                owner_q, owner_d;
  logic [3:0]          burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [LFSR_W-1:0]   rnd_q, rnd_d;

  logic [LFSR_W-1:0]   lfsr_state;
  logic [NUM_REQ-1:0]  others;
  logic                grant;
  ptr_t                winner;

  // First set bit of mask scanning upward from start, wrapping at NUM_REQ.
  function automatic ptr_t rr_pick(input logic [NUM_REQ-1:0] mask, input ptr_t start);
    ptr_t pick;
    ptr_t idx;
    logic found;
    int   s;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s = int'(start) + i;
      if (s >= NUM_REQ) begin
        s = s - NUM_REQ;
      end
      idx = ptr_t'(s);
      if (!found && mask[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt_d       = '0;
    rnd_d       = rnd_q;
    grant       = 1'b0;
    winner      = owner_q;
    others      = req;
    others[owner_q] = 1'b0;

    if (seed_load) begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant       = 1'b1;
            winner      = rr_pick(req, ptr_q);
            burst_cnt_d = 4'd1;
          end
        end
        GRANT: begin
          // A lone owner may keep going past the burst limit; the count restarts.
          if (req[owner_q] && ((burst_cnt_q < BURST_MAX) || !(|others))) begin
            grant       = 1'b1;
            winner      = owner_q;
            burst_cnt_d = (burst_cnt_q < BURST_MAX) ? burst_cnt_q + 4'd1 : 4'd1;
          end else if (|others) begin
            grant       = 1'b1;
            winner      = rr_pick(others, ptr_q);
            burst_cnt_d = 4'd1;
          end else begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end
        end
        default: begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end
      endcase
    end

    if (grant) begin
      state_d        = GRANT;
      owner_d        = winner;
      gnt_d[winner]  = 1'b1;
      rnd_d          = lfsr_state;
      ptr_d          = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      gnt_q       <= '0;
      rnd_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
      rnd_q       <= rnd_d;
    end
  end

  lfsr_core #(
    .SEED(SEED_DEFAULT)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .step    (grant),
    .load    (seed_load),
    .load_val(seed_in),
    .state   (lfsr_state)
  );

  assign gnt      = gnt_q;
  assign rnd_data = rnd_q;
  assign data     = lfsr_state;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench: a behavioural arbitration/LFSR model is compared every cycle,
// and directed scenarios pin the model with hand-computed literal values.
module tb_lfsr_arbiter;

  localparam int N  = 4;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         seed_load;
  logic [7:0]   seed_in;
  logic [N-1:0] gnt;
  logic [7:0]   rnd_data;
  logic [7:0]   data;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  lfsr_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .seed_load(seed_load),
    .seed_in  (seed_in),
    .gnt      (gnt),
    .rnd_data (rnd_data),
    .data     (data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_val   = 8'h8A;
  int         m_owner = -1;
  int         m_burst = 0;
  int         m_ptr   = 0;
  logic [7:0] e_rnd   = 8'h00;
  logic [N-1:0] e_gnt = '0;

  function automatic logic [7:0] nxt(input logic [7:0] b);
    logic [7:0] taps;
    taps = b & 8'h1D;
    return {^taps, b[7:1]};
  endfunction

  task automatic model_edge(input logic rst_n, input logic [N-1:0] r,
                            input logic sl, input logic [7:0] si);
    int w;
    int j;
    int n_other;
    if (!rst_n) begin
      m_val = 8'h8A; m_owner = -1; m_burst = 0; m_ptr = 0; e_rnd = 8'h00; e_gnt = '0;
    end else if (sl) begin
      m_val = (si == 8'h00) ? 8'h8A : si;
      m_owner = -1; m_burst = 0; e_gnt = '0;
    end else begin
      w = -1;
      n_other = 0;
      for (int k = 0; k < N; k++) if (k != m_owner && r[k]) n_other++;
      if (m_owner >= 0 && r[m_owner] && (m_burst < BL || n_other == 0)) begin
        w = m_owner;
        m_burst = (m_burst < BL) ? m_burst + 1 : 1;
      end else begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && j != m_owner && r[j]) w = j;
        end
        m_burst = (w >= 0) ? 1 : 0;
      end
      if (w >= 0) begin
        e_gnt   = N'(1 << w);
        e_rnd   = m_val;
        m_val   = nxt(m_val);
        m_ptr   = (w + 1) % N;
        m_owner = w;
      end else begin
        e_gnt   = '0;
        m_owner = -1;
      end
    end
  endtask

  // Single compare process: advance the model on each edge, check just after it.
  always begin
    @(posedge clk);
    model_edge(reset, req, seed_load, seed_in);
    #1;
    chk("m_gnt",  32'(gnt),      32'(e_gnt));
    chk("m_rnd",  32'(rnd_data), 32'(e_rnd));
    chk("m_data", 32'(data),     32'(m_val));
    chk("m_busy", 32'(busy),     32'(m_owner >= 0));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  int exp_owner [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
  logic [7:0] first_bytes [4] = '{8'h8A, 8'hC5, 8'h62, 8'h31};
  logic [N-1:0] onehot;

  initial begin
    reset = 1'b0; req = '0; seed_load = 1'b0; seed_in = 8'h00;
    cyc(); cyc();
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_gnt",  32'(gnt), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rnd",  32'(rnd_data), 32'h00);
      chk("idle_data", 32'(data), 32'h8A);
    end

    // Single requester, three bytes
    req = 4'b0001;
    cyc(); chk("s1_gnt", 32'(gnt), 32'h1); chk("s1_rnd", 32'(rnd_data), 32'h8A);
    cyc(); chk("s2_gnt", 32'(gnt), 32'h1); chk("s2_rnd", 32'(rnd_data), 32'hC5);
    cyc(); chk("s3_gnt", 32'(gnt), 32'h1); chk("s3_rnd", 32'(rnd_data), 32'h62);
    req = 4'b0000;
    cyc(); chk("s4_gnt", 32'(gnt), 0); chk("s4_data", 32'(data), 32'h31);

    // Reset to put pointer back at 0 and LFSR at the default seed
    reset = 1'b0; cyc(); reset = 1'b1;

    // All requesting: bursts of BURST_LEN in round-robin order
    req = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      cyc();
      onehot = '0;
      onehot[exp_owner[i]] = 1'b1;
      chk("rr_gnt", 32'(gnt), 32'(onehot));
      if (i < 4) chk("rr_rnd", 32'(rnd_data), 32'(first_bytes[i]));
    end

    // Zero seed during a burst falls back to the default
    seed_load = 1'b1; seed_in = 8'h00;
    cyc(); seed_load = 1'b0;
    chk("ld0_gnt", 32'(gnt), 0); chk("ld0_busy", 32'(busy), 0); chk("ld0_data", 32'(data), 32'h8A);
    cyc(); chk("ld0_rnd", 32'(rnd_data), 32'h8A); chk("ld0_gnt2", 32'(gnt), 32'h2);

    seed_load = 1'b1; seed_in = 8'h5A;
    cyc(); seed_load = 1'b0;
    chk("ld5a_gnt", 32'(gnt), 0); chk("ld5a_data", 32'(data), 32'h5A);
    cyc(); chk("ld5a_rnd", 32'(rnd_data), 32'h5A);

    // Reset mid-burst
    req = 4'b0110;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_gnt", 32'(gnt), 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_rnd", 32'(rnd_data), 32'h00); chk("rst_data", 32'(data), 32'h8A);
    reset = 1'b1;
    cyc(); chk("rst_first", 32'(gnt), 32'h2); chk("rst_first_rnd", 32'(rnd_data), 32'h8A);

    // Full period on one requester
    req = '0;
    reset = 1'b0; cyc(); reset = 1'b1;
    req = 4'b0001;
    for (int g = 1; g <= 256; g++) begin
      cyc();
      chk("per_gnt", 32'(gnt), 32'h1);
      checks++;
      if (rnd_data == 8'h00) begin
        failures++;
        $display("FAIL per_nonzero actual=%0h required=nonzero at grant %0d", rnd_data, g);
      end
      if (g == 1 || g == 256) chk("per_wrap", 32'(rnd_data), 32'h8A);
      if (g == 2) chk("per_second", 32'(rnd_data), 32'hC5);
    end
    req = '0;
    cyc(); chk("end_gnt", 32'(gnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
